rx_arb_push: RTL and testbench

Parametrised successor of the router's receive-side push logic. It accepts data items from PORTS senders over two-phase (toggle) req/ack handshakes and arbitrates one winner per cycle, using either round-robin or fixed priority. The winner's item goes to the input-buffer FIFO. Free-slot tracking is credit-based and internal, so a write is never issued to a full FIFO and the FIFO's full flag is not needed.

---
 rtl/rx_arb_push_if.sv | 45 ++++
 rtl/rx_arb_push.sv | 153 +++++++++++++++
 tb/tb_rx_arb_push.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_arb_push_if.sv
// rx_arb_push_if
// Bundles the sender push handshake, the FIFO write side and the status
// outputs of rx_arb_push.
//   master : the sender/FIFO environment (drives req, data, pop)
//   slave  : rx_arb_push itself (drives ack, write, data_in, status)
// Signals:
//   fifo_push_req  [PORTS]      per-sender toggle request
//   fifo_push_data [SIZE*PORTS] item of sender i at [SIZE*i +: SIZE]
//   fifo_push_ack  [PORTS]      per-sender toggle acknowledge
//   fifo_write                  one-cycle FIFO write strobe
//   fifo_data_in   [SIZE]       item written with fifo_write
//   fifo_pop                    consumer removed one FIFO entry
//   grant_port     [GW]         sender index of the current write
//   credits        [CW]         free FIFO entries tracked by the arbiter
//   err_overflow                sticky: pop seen with all credits free
interface rx_arb_push_if #(
  parameter int SIZE  = 8,
  parameter int PORTS = 5,
  parameter int DEPTH = 4
);
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PORTS-1:0]      fifo_push_req;
  logic [SIZE*PORTS-1:0] fifo_push_data;
  logic [PORTS-1:0]      fifo_push_ack;
  logic                  fifo_write;
  logic [SIZE-1:0]       fifo_data_in;
  logic                  fifo_pop;
  logic [GW-1:0]         grant_port;
  logic [CW-1:0]         credits;
  logic                  err_overflow;

  modport master (
    output fifo_push_req, fifo_push_data, fifo_pop,
    input  fifo_push_ack, fifo_write, fifo_data_in, grant_port, credits,
           err_overflow
  );

  modport slave (
    input  fifo_push_req, fifo_push_data, fifo_pop,
    output fifo_push_ack, fifo_write, fifo_data_in, grant_port, credits,
           err_overflow
  );
endinterface

// File: rtl/rx_arb_push.sv
// rx_arb_push
// Receive-side push arbiter. PORTS senders offer items over two-phase
// (toggle) req/ack handshakes; one winner per cycle is written into the
// downstream input-buffer FIFO. Free FIFO slots are tracked locally with
// credits so a write never targets a full FIFO.
// Ports:
//   clk    single clock, posedge
//   reset  synchronous, active-high
//   bus    rx_arb_push_if.slave (handshakes, FIFO write side, status)
// Parameters:
//   SIZE  item width, PORTS sender count (>=2), DEPTH FIFO entries (>=1),
//   MODE  0 = fixed priority (lowest index), 1 = round-robin

// Per-sender handshake lane: owns the ack toggle and exposes "pending".
module rx_arb_push_lane (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_grant,
  output logic o_ack,
  output logic o_pend
);
  logic r_ack;

  always_ff @(posedge clk) begin
    if (reset)        r_ack <= 1'b0;
    else if (i_grant) r_ack <= ~r_ack;
  end

  assign o_ack  = r_ack;
  // Two-phase handshake: an item is outstanding while req and ack differ.
  assign o_pend = i_req ^ r_ack;
endmodule

module rx_arb_push #(
  parameter int SIZE  = 8,
  parameter int PORTS = 5,
  parameter int DEPTH = 4,
  parameter int MODE  = 1
) (
  input  logic          clk,
  input  logic          reset,
  rx_arb_push_if.slave  bus
);
  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PORTS-1:0]           w_pend;
  logic [PORTS-1:0]           w_ack;
  logic [PORTS-1:0]           w_gnt_vec;
  logic [PORTS-1:0][SIZE-1:0] w_data;

  logic [GW-1:0]   w_base;
  logic [GW:0]     w_dist;
  logic [GW:0]     w_best;
  logic [GW-1:0]   w_win;
  logic            w_found;
  logic            w_elig;
  logic            w_grant;

  logic [GW-1:0]   r_rr;
  logic            r_write;
  logic [SIZE-1:0] r_data;
  logic [GW-1:0]   r_gp;
  logic [CW-1:0]   r_credits;
  logic            r_err;

  assign w_data = bus.fifo_push_data;

  // ---------------------------------------------------------------------
  // Handshake lanes
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < PORTS; i++) begin : g_lane
    rx_arb_push_lane u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_req   (bus.fifo_push_req[i]),
      .i_grant (w_gnt_vec[i]),
      .o_ack   (w_ack[i]),
      .o_pend  (w_pend[i])
    );
  end

  // ---------------------------------------------------------------------
  // Winner select
  // Each pending port is ranked by its distance above the search base,
  // measured modulo PORTS; the smallest distance wins. Fixed priority is
  // simply round-robin with the base pinned at port 0.
  // ---------------------------------------------------------------------
  assign w_base = (MODE == 1) ? r_rr : '0;

  always_comb begin
    w_found = 1'b0;
    w_best  = '0;
    w_win   = '0;
    w_dist  = '0;
    for (int j = 0; j < PORTS; j++) begin
      if ((GW+1)'(j) >= {1'b0, w_base})
        w_dist = (GW+1)'(j) - {1'b0, w_base};
      else
        w_dist = (GW+1)'(j) + (GW+1)'(PORTS) - {1'b0, w_base};
      if (w_pend[j] && (!w_found || (w_dist < w_best))) begin
        w_found = 1'b1;
        w_best  = w_dist;
        w_win   = GW'(j);
      end
    end
  end

  // A pop in the same cycle frees a slot on this edge, so it makes a
  // grant legal even with zero credits.
  assign w_elig    = (r_credits != '0) || bus.fifo_pop;
  assign w_grant   = w_found && w_elig;
  assign w_gnt_vec = w_grant ? (PORTS'(1) << w_win) : '0;

  // ---------------------------------------------------------------------
  // Write port, pointer and credit state
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write   <= 1'b0;
      r_data    <= '0;
      r_gp      <= '0;
      r_rr      <= '0;
      r_credits <= CW'(DEPTH);
      r_err     <= 1'b0;
    end else begin
      r_write <= w_grant;
      if (w_grant) begin
        r_data <= w_data[w_win];
        r_gp   <= w_win;
        r_rr   <= (w_win == GW'(PORTS - 1)) ? '0 : w_win + GW'(1);
      end
      // Grant and pop together cancel; a pop with every slot already free
      // has nothing to return and is flagged instead.
      case ({w_grant, bus.fifo_pop})
        2'b10: r_credits <= r_credits - CW'(1);
        2'b01: begin
          if (r_credits < CW'(DEPTH)) r_credits <= r_credits + CW'(1);
          else                        r_err     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_push_ack = w_ack;
  assign bus.fifo_write    = r_write;
  assign bus.fifo_data_in  = r_data;
  assign bus.grant_port    = r_gp;
  assign bus.credits       = r_credits;
  assign bus.err_overflow  = r_err;
endmodule

// File: tb/tb_rx_arb_push.sv
module tb_rx_arb_push;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstA, rstB;
  logic [4:0]      reqA, reqB;
  logic [4:0][7:0] da, db;
  logic            popA, popB;

  rx_arb_push_if #(.SIZE(8), .PORTS(5), .DEPTH(4)) ia ();
  rx_arb_push_if #(.SIZE(8), .PORTS(5), .DEPTH(2)) ib ();

  assign ia.fifo_push_req  = reqA;
  assign ia.fifo_push_data = da;
  assign ia.fifo_pop       = popA;
  assign ib.fifo_push_req  = reqB;
  assign ib.fifo_push_data = db;
  assign ib.fifo_pop       = popB;

  // A: round-robin, 4-deep FIFO.  B: fixed priority, 2-deep FIFO.
  rx_arb_push #(.SIZE(8), .PORTS(5), .DEPTH(4), .MODE(1)) dut_a (
    .clk(clk), .reset(rstA), .bus(ia.slave));
  rx_arb_push #(.SIZE(8), .PORTS(5), .DEPTH(2), .MODE(0)) dut_b (
    .clk(clk), .reset(rstB), .bus(ib.slave));

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [4:0] tog;
    logic       pop;
    logic       wr;
    logic [2:0] gp;
    logic [7:0] data;
    logic [2:0] cr;
    logic [4:0] ack;
    logic       err;
  } vec_t;

  vec_t tblA[15];
  vec_t tblB[10];

  function automatic logic [20:0] pk(logic wr, logic [2:0] gp, logic [7:0] d,
                                     logic [2:0] cr, logic [4:0] ack, logic err);
    return {wr, gp, d, cr, ack, err};
  endfunction

  function automatic logic [20:0] obsA();
    return pk(ia.fifo_write, ia.grant_port, ia.fifo_data_in, ia.credits,
              ia.fifo_push_ack, ia.err_overflow);
  endfunction

  function automatic logic [20:0] obsB();
    return pk(ib.fifo_write, ib.grant_port, ib.fifo_data_in, {1'b0, ib.credits},
              ib.fifo_push_ack, ib.err_overflow);
  endfunction

  // Fields in report: {wr,gp[3],data[8],credits[3],ack[5],err}
  task automatic cmp(input string nm, input logic [20:0] act, input logic [20:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic stepA(input logic [4:0] tog, input logic pop, input logic [4:0][7:0] nd);
    @(negedge clk);
    for (int p = 0; p < 5; p++)
      if (tog[p]) begin
        reqA[p] = ~reqA[p];
        da[p]   = nd[p];
      end
    popA = pop;
    @(posedge clk);
    #1;
  endtask

  task automatic stepB(input logic [4:0] tog, input logic pop);
    @(negedge clk);
    for (int p = 0; p < 5; p++)
      if (tog[p]) reqB[p] = ~reqB[p];
    popB = pop;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference for DUT A (round-robin, DEPTH 4)
  bit         off[5];
  logic [7:0] mdata[5];
  int         mcr, mrr;
  logic [4:0] mack;
  logic       mwr, merr;
  logic [2:0] mgp;
  logic [7:0] mdat;

  initial begin
    //            tog       pop   wr    gp    data   cr    ack       err
    tblA[0]  = '{5'b00100, 1'b0, 1'b1, 3'd2, 8'hA5, 3'd3, 5'b00100, 1'b0};
    tblA[1]  = '{5'b00000, 1'b0, 1'b0, 3'd2, 8'hA5, 3'd3, 5'b00100, 1'b0};
    tblA[2]  = '{5'b11111, 1'b0, 1'b1, 3'd3, 8'hA6, 3'd2, 5'b01100, 1'b0};
    tblA[3]  = '{5'b00000, 1'b0, 1'b1, 3'd4, 8'hA7, 3'd1, 5'b11100, 1'b0};
    tblA[4]  = '{5'b00000, 1'b0, 1'b1, 3'd0, 8'hA3, 3'd0, 5'b11101, 1'b0};
    tblA[5]  = '{5'b00000, 1'b0, 1'b0, 3'd0, 8'hA3, 3'd0, 5'b11101, 1'b0};
    tblA[6]  = '{5'b00000, 1'b1, 1'b1, 3'd1, 8'hA4, 3'd0, 5'b11111, 1'b0};
    tblA[7]  = '{5'b00000, 1'b1, 1'b1, 3'd2, 8'hA5, 3'd0, 5'b11011, 1'b0};
    tblA[8]  = '{5'b00000, 1'b1, 1'b0, 3'd2, 8'hA5, 3'd1, 5'b11011, 1'b0};
    tblA[9]  = '{5'b00000, 1'b1, 1'b0, 3'd2, 8'hA5, 3'd2, 5'b11011, 1'b0};
    tblA[10] = '{5'b00001, 1'b1, 1'b1, 3'd0, 8'hA3, 3'd2, 5'b11010, 1'b0};
    tblA[11] = '{5'b00000, 1'b1, 1'b0, 3'd0, 8'hA3, 3'd3, 5'b11010, 1'b0};
    tblA[12] = '{5'b00000, 1'b1, 1'b0, 3'd0, 8'hA3, 3'd4, 5'b11010, 1'b0};
    tblA[13] = '{5'b00000, 1'b1, 1'b0, 3'd0, 8'hA3, 3'd4, 5'b11010, 1'b1};
    tblA[14] = '{5'b00000, 1'b0, 1'b0, 3'd0, 8'hA3, 3'd4, 5'b11010, 1'b1};

    // Fixed priority with port 1 re-requesting, then credit exhaustion
    tblB[0]  = '{5'b01010, 1'b0, 1'b1, 3'd1, 8'h51, 3'd1, 5'b00010, 1'b0};
    tblB[1]  = '{5'b00010, 1'b1, 1'b1, 3'd1, 8'h51, 3'd1, 5'b00000, 1'b0};
    tblB[2]  = '{5'b00010, 1'b1, 1'b1, 3'd1, 8'h51, 3'd1, 5'b00010, 1'b0};
    tblB[3]  = '{5'b00000, 1'b1, 1'b1, 3'd3, 8'h53, 3'd1, 5'b01010, 1'b0};
    tblB[4]  = '{5'b00000, 1'b1, 1'b0, 3'd3, 8'h53, 3'd2, 5'b01010, 1'b0};
    tblB[5]  = '{5'b00111, 1'b0, 1'b1, 3'd0, 8'h50, 3'd1, 5'b01011, 1'b0};
    tblB[6]  = '{5'b00000, 1'b0, 1'b1, 3'd1, 8'h51, 3'd0, 5'b01001, 1'b0};
    tblB[7]  = '{5'b00000, 1'b0, 1'b0, 3'd1, 8'h51, 3'd0, 5'b01001, 1'b0};
    tblB[8]  = '{5'b00000, 1'b1, 1'b1, 3'd2, 8'h52, 3'd0, 5'b01101, 1'b0};
    tblB[9]  = '{5'b00000, 1'b0, 1'b0, 3'd2, 8'h52, 3'd0, 5'b01101, 1'b0};

    rstA = 1'b1; rstB = 1'b1;
    reqA = '0; reqB = '0; popA = 1'b0; popB = 1'b0;
    for (int p = 0; p < 5; p++) begin
      da[p] = 8'hA3 + 8'(p);
      db[p] = 8'h50 + 8'(p);
    end
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state_a", obsA(), pk(1'b0, 3'd0, 8'h00, 3'd4, 5'b0, 1'b0));
    cmp("reset_state_b", obsB(), pk(1'b0, 3'd0, 8'h00, 3'd2, 5'b0, 1'b0));
    @(negedge clk);
    rstA = 1'b0; rstB = 1'b0;

    foreach (tblA[i]) begin
      stepA(tblA[i].tog, tblA[i].pop, da);
      cmp($sformatf("tblA[%0d]", i), obsA(),
          pk(tblA[i].wr, tblA[i].gp, tblA[i].data, tblA[i].cr, tblA[i].ack, tblA[i].err));
    end
    foreach (tblB[i]) begin
      stepB(tblB[i].tog, tblB[i].pop);
      cmp($sformatf("tblB[%0d]", i), obsB(),
          pk(tblB[i].wr, tblB[i].gp, tblB[i].data, tblB[i].cr, tblB[i].ack, tblB[i].err));
    end

    // Reset on an edge where port 1 would otherwise be granted
    @(negedge clk);
    popA = 1'b0;
    rstA = 1'b1;
    reqA[1] = ~reqA[1];
    @(posedge clk);
    #1;
    cmp("reset_mid_grant", obsA(), pk(1'b0, 3'd0, 8'h00, 3'd4, 5'b0, 1'b0));
    @(negedge clk);
    reqA = '0;
    rstA = 1'b0;
    @(posedge clk);
    #1;
    cmp("after_reset_idle", obsA(), pk(1'b0, 3'd0, 8'h00, 3'd4, 5'b0, 1'b0));

    // Randomised traffic against the reference model
    mcr = 4; mrr = 0; mack = '0; mwr = 1'b0; merr = 1'b0; mgp = '0; mdat = '0;
    for (int p = 0; p < 5; p++) begin off[p] = 1'b0; mdata[p] = '0; end
    for (int c = 0; c < 400; c++) begin
      logic [4:0]      tog;
      logic [4:0][7:0] nd;
      logic            pop;
      int              w;
      tog = '0;
      nd  = '0;
      for (int p = 0; p < 5; p++)
        if (!off[p] && ($urandom_range(0, 2) == 0)) begin
          tog[p]   = 1'b1;
          nd[p]    = 8'($urandom);
          off[p]   = 1'b1;
          mdata[p] = nd[p];
        end
      pop = ($urandom_range(0, 9) < 3);
      w = -1;
      if (mcr > 0 || pop)
        for (int k = 0; k < 5; k++)
          if (w < 0 && off[(mrr + k) % 5]) w = (mrr + k) % 5;
      if (w >= 0) begin
        mack[w] = ~mack[w];
        off[w]  = 1'b0;
        mwr     = 1'b1;
        mgp     = 3'(w);
        mdat    = mdata[w];
        mrr     = (w + 1) % 5;
      end else begin
        mwr = 1'b0;
      end
      if (w >= 0 && !pop)      mcr--;
      else if (w < 0 && pop) begin
        if (mcr < 4) mcr++;
        else         merr = 1'b1;
      end
      stepA(tog, pop, nd);
      cmp($sformatf("rand[%0d]", c), obsA(), pk(mwr, mgp, mdat, 3'(mcr), mack, merr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
